// File: rtl/elev_pkg.sv
// Shared elevator-controller definitions: floor geometry plus the scheduler and
// elevator FSM state encodings, so both FSMs agree on one set of values.
package elev_pkg;

    localparam int NUM_FLOORS = 10;
    localparam int FLOOR_W    = 4;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_SERVE = 2'd1,
        SCHED_DWELL = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        ELEV_IDLE = 2'd0,
        ELEV_UP   = 2'd1,
        ELEV_DOWN = 2'd2
    } elev_state_t;

endpackage

// File: rtl/floor_request_scheduler_if.sv
// Button / floor-position / target bundle between the request scheduler (master)
// and the elevator FSM plus panel hardware (slave).
interface floor_request_scheduler_if #(
    parameter int NUM_FLOORS = elev_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elev_pkg::FLOOR_W
);
    logic [NUM_FLOORS-1:0] btn;
    logic [FLOOR_W-1:0]    current_floor;
    logic [FLOOR_W-1:0]    requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  door_open;
    logic                  busy;

    modport master (
        input  btn, current_floor,
        output requested_floor, pending, dir_up, door_open, busy
    );

    modport slave (
        output btn, current_floor,
        input  requested_floor, pending, dir_up, door_open, busy
    );
endinterface

// File: rtl/req_sync_edge.sv
// Multi-flop synchroniser for a vector of asynchronous buttons, followed by a
// registered rising-edge detector: one single-cycle pulse per press.
module req_sync_edge #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] last_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            last_p <= '0;
            rise   <= '0;
        end else begin
            sync_p[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            // edge-detect stage: compare synchronised level with its previous value
            last_p <= sync_p[SYNC_STAGES-1];
            rise   <= sync_p[SYNC_STAGES-1] & ~last_p;
        end
    end
endmodule

// File: rtl/floor_request_scheduler.sv
// Elevator request scheduler: keeps the pending-floor bitmap, picks the next target
// with SCAN ordering, and holds the door open for a dwell period at each served floor.
module floor_request_scheduler #(
    parameter int NUM_FLOORS   = elev_pkg::NUM_FLOORS,
    parameter int FLOOR_W      = elev_pkg::FLOOR_W,
    parameter int SYNC_STAGES  = 2,
    parameter int DWELL_CYCLES = 20000000
) (
    input  logic                      clk,
    input  logic                      reset,
    floor_request_scheduler_if.master bus
);
    import elev_pkg::*;

    localparam int               CNT_W      = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    sched_state_t          state;
    logic [CNT_W-1:0]      dwell_cnt;
    logic [FLOOR_W-1:0]    req_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic                  dir_q;
    logic                  door_q;

    logic [NUM_FLOORS-1:0] press, here_mask, target_mask, set_mask, clr_mask;
    logic                  cf_legal, at_target;
    logic                  above_vld, below_vld, sel_vld, sel_dir_up;
    logic [FLOOR_W-1:0]    above_flr, below_flr, sel_flr;

    req_sync_edge #(.WIDTH(NUM_FLOORS), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.btn),
        .rise  (press)
    );

    assign cf_legal  = ({1'b0, bus.current_floor} < (FLOOR_W+1)'(NUM_FLOORS));
    assign at_target = (bus.current_floor == req_q);

    always_comb begin
        here_mask   = '0;
        target_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            here_mask[i]   = (bus.current_floor == FLOOR_W'(i));
            target_mask[i] = (req_q == FLOOR_W'(i));
        end
    end

    // A press for the floor we are standing at (not travelling through) is already satisfied.
    assign set_mask = cf_legal ? (press & ~((state != SCHED_SERVE) ? here_mask : '0)) : '0;
    assign clr_mask = (cf_legal && state == SCHED_SERVE && at_target) ? target_mask : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending_q <= '0;
        else       pending_q <= (pending_q | set_mask) & ~clr_mask;
    end

    // Descending scan leaves the lowest floor above; ascending scan leaves the highest below.
    always_comb begin
        above_vld = 1'b0;
        above_flr = '0;
        below_vld = 1'b0;
        below_flr = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (pending_q[i] && FLOOR_W'(i) > bus.current_floor) begin
                above_vld = 1'b1;
                above_flr = FLOOR_W'(i);
            end
        for (int i = 0; i < NUM_FLOORS; i++)
            if (pending_q[i] && FLOOR_W'(i) < bus.current_floor) begin
                below_vld = 1'b1;
                below_flr = FLOOR_W'(i);
            end
    end

    always_comb begin
        sel_vld    = above_vld | below_vld;
        sel_flr    = '0;
        sel_dir_up = dir_q;
        if (dir_q) begin
            if (above_vld)      begin sel_flr = above_flr; sel_dir_up = 1'b1; end
            else if (below_vld) begin sel_flr = below_flr; sel_dir_up = 1'b0; end
        end else begin
            if (below_vld)      begin sel_flr = below_flr; sel_dir_up = 1'b0; end
            else if (above_vld) begin sel_flr = above_flr; sel_dir_up = 1'b1; end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCHED_IDLE;
            req_q     <= '0;
            dir_q     <= 1'b1;
            door_q    <= 1'b0;
            dwell_cnt <= '0;
        end else if (cf_legal) begin
            unique case (state)
                SCHED_IDLE: begin
                    if (sel_vld) begin
                        req_q <= sel_flr;
                        dir_q <= sel_dir_up;
                        state <= SCHED_SERVE;
                    end else begin
                        req_q <= bus.current_floor;
                    end
                end
                SCHED_SERVE: begin
                    if (at_target) begin
                        dwell_cnt <= DWELL_LOAD;
                        door_q    <= 1'b1;
                        state     <= SCHED_DWELL;
                    end else if (dir_q && above_vld && above_flr < req_q) begin
                        req_q <= above_flr;
                    end else if (!dir_q && below_vld && below_flr > req_q) begin
                        req_q <= below_flr;
                    end
                end
                SCHED_DWELL: begin
                    req_q <= bus.current_floor;
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else begin
                        door_q <= 1'b0;
                        if (sel_vld) begin
                            req_q <= sel_flr;
                            dir_q <= sel_dir_up;
                            state <= SCHED_SERVE;
                        end else begin
                            state <= SCHED_IDLE;
                        end
                    end
                end
                default: state <= SCHED_IDLE;
            endcase
        end
    end

    assign bus.requested_floor = req_q;
    assign bus.pending         = pending_q;
    assign bus.dir_up          = dir_q;
    assign bus.door_open       = door_q;
    assign bus.busy            = (state != SCHED_IDLE) || (|pending_q);

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler with a simple elevator model that
// moves one floor every 3 clocks toward requested_floor, or a manually driven floor.
module tb_floor_request_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b0;

    floor_request_scheduler_if #(.NUM_FLOORS(10), .FLOOR_W(4)) bus ();

    floor_request_scheduler #(
        .NUM_FLOORS   (10),
        .FLOOR_W      (4),
        .SYNC_STAGES  (2),
        .DWELL_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic       model_en     = 1'b0;
    logic [3:0] manual_floor = 4'd0;
    logic [3:0] model_floor  = 4'd0;
    int         model_cnt    = 0;

    assign bus.current_floor = model_en ? model_floor : manual_floor;

    // Elevator stand-in: one floor step every third clock while away from the target.
    always @(posedge clk) begin
        if (!model_en) begin
            model_floor <= manual_floor;
            model_cnt   <= 0;
        end else if (model_floor != bus.requested_floor) begin
            if (model_cnt == 2) begin
                model_cnt   <= 0;
                model_floor <= (model_floor < bus.requested_floor) ? model_floor + 4'd1
                                                                    : model_floor - 4'd1;
            end else begin
                model_cnt <= model_cnt + 1;
            end
        end else begin
            model_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int f);
        bus.btn    = '0;
        bus.btn[f] = 1'b1;
        tick(1);
        bus.btn    = '0;
    endtask

    // Waits for the door to open, reports the floor and how long the door stayed open.
    task automatic serve_wait(input string tag, output logic [3:0] flr, output int dwell);
        int n;
        n = 0;
        while (!bus.door_open && n < 300) begin
            tick(1);
            n++;
        end
        chk({tag, "_arrive"}, {31'd0, bus.door_open}, 32'd1);
        flr   = bus.current_floor;
        dwell = 0;
        while (bus.door_open && dwell < 20) begin
            tick(1);
            dwell++;
        end
    endtask

    initial begin
        logic [3:0] f;
        int         dw;
        int         n;

        bus.btn = '0;

        // 1: reset values, single press, arrival and dwell
        #2 reset = 1'b1;
        #1;
        chk("rst_req",     {28'd0, bus.requested_floor}, 32'd0);
        chk("rst_pending", {22'd0, bus.pending},         32'd0);
        chk("rst_dir",     {31'd0, bus.dir_up},          32'd1);
        chk("rst_door",    {31'd0, bus.door_open},       32'd0);
        chk("rst_busy",    {31'd0, bus.busy},            32'd0);
        tick(2);
        reset    = 1'b0;
        model_en = 1'b1;
        tick(2);
        press(5);
        tick(2);
        chk("t1_pending_early", {22'd0, bus.pending}, 32'd0);
        tick(1);
        chk("t1_pending", {22'd0, bus.pending}, 32'h020);
        tick(1);
        chk("t1_req", {28'd0, bus.requested_floor}, 32'd5);
        chk("t1_dir", {31'd0, bus.dir_up}, 32'd1);
        serve_wait("t1", f, dw);
        chk("t1_floor",   {28'd0, f}, 32'd5);
        chk("t1_dwell",   dw, 32'd4);
        chk("t1_cleared", {22'd0, bus.pending}, 32'd0);
        chk("t1_busy",    {31'd0, bus.busy}, 32'd0);

        // 2: at 5 going up with {2,8} pending -> 8 then 2
        bus.btn = 10'h104;
        tick(1);
        bus.btn = '0;
        serve_wait("t2a", f, dw);
        chk("t2_first", {28'd0, f}, 32'd8);
        serve_wait("t2b", f, dw);
        chk("t2_second", {28'd0, f}, 32'd2);
        chk("t2_dir",    {31'd0, bus.dir_up}, 32'd0);

        // 3: en-route pickup of 3 while travelling 0 -> 7
        press(0);
        serve_wait("t3_home", f, dw);
        chk("t3_home", {28'd0, f}, 32'd0);
        press(7);
        n = 0;
        while (bus.current_floor != 4'd1 && n < 100) begin
            tick(1);
            n++;
        end
        chk("t3_at1", {28'd0, bus.current_floor}, 32'd1);
        press(3);
        tick(4);
        chk("t3_retarget", {28'd0, bus.requested_floor}, 32'd3);
        serve_wait("t3a", f, dw);
        chk("t3_first", {28'd0, f}, 32'd3);
        serve_wait("t3b", f, dw);
        chk("t3_second", {28'd0, f}, 32'd7);

        // 4: held button sets once; press at current floor in IDLE is ignored
        manual_floor = bus.current_floor;
        model_en     = 1'b0;
        bus.btn[4]   = 1'b1;
        tick(6);
        chk("t4_set", {22'd0, bus.pending}, 32'h010);
        manual_floor = 4'd4;
        tick(1);
        chk("t4_door",    {31'd0, bus.door_open}, 32'd1);
        chk("t4_cleared", {22'd0, bus.pending},   32'd0);
        tick(6);
        manual_floor = 4'd5;
        tick(37);
        chk("t4_held_once", {22'd0, bus.pending}, 32'd0);
        chk("t4_idle",      {31'd0, bus.busy},    32'd0);
        bus.btn = '0;
        tick(2);
        press(5);
        tick(6);
        chk("t4_here_ignored", {22'd0, bus.pending}, 32'd0);
        chk("t4_here_busy",    {31'd0, bus.busy},    32'd0);

        // 5: press for 6 lands on the arrival cycle at 6 -> clear wins
        manual_floor = 4'd3;
        tick(1);
        press(6);
        tick(4);
        chk("t5_req",     {28'd0, bus.requested_floor}, 32'd6);
        chk("t5_dir",     {31'd0, bus.dir_up},          32'd1);
        chk("t5_pending", {22'd0, bus.pending},         32'h040);
        press(6);
        tick(2);
        manual_floor = 4'd6;
        tick(1);
        chk("t5_clear_wins", {22'd0, bus.pending},   32'd0);
        chk("t5_door",       {31'd0, bus.door_open}, 32'd1);
        tick(6);

        // 6: asynchronous reset in the middle of a SERVE
        manual_floor = 4'd0;
        tick(2);
        bus.btn = 10'h3F0;
        tick(1);
        bus.btn = '0;
        tick(4);
        chk("t6_pending", {22'd0, bus.pending},         32'h3F0);
        chk("t6_req",     {28'd0, bus.requested_floor}, 32'd4);
        chk("t6_busy",    {31'd0, bus.busy},            32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_req",     {28'd0, bus.requested_floor}, 32'd0);
        chk("t6_rst_pending", {22'd0, bus.pending},         32'd0);
        chk("t6_rst_dir",     {31'd0, bus.dir_up},          32'd1);
        chk("t6_rst_door",    {31'd0, bus.door_open},       32'd0);
        chk("t6_rst_busy",    {31'd0, bus.busy},            32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
